// File: rtl/pola_yolo_detection_packer_if.sv
// Record handshake toward the result writer.
// Master presents packed detections; slave returns ready.
interface pola_yolo_detection_packer_if #(
  parameter int Data_bit  = 16,
  parameter int Class_bit = 8
) ();
  logic                            out_valid;
  logic                            out_ready;
  logic [4*Data_bit+Class_bit-1:0] out_data;
  logic                            out_null;
  logic                            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_null,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_null,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pola_yolo_detection_packer.sv
// Packs confidence-gated candidates into a record FIFO with
// end-of-frame marking, per-frame counts and sticky loss flag.
module pola_yolo_detection_packer #(
  parameter int Data_bit   = 16,
  parameter int Class_bit  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                       M_AXI_ACLK,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [Data_bit-1:0] in_x,
  input  logic signed [Data_bit-1:0] in_y,
  input  logic signed [Data_bit-1:0] in_w,
  input  logic signed [Data_bit-1:0] in_h,
  input  logic [Class_bit-1:0]       in_class,
  input  logic                       in_frame_last,
  pola_yolo_detection_packer_if.master out_if,
  output logic [CNT_W-1:0]           det_count,
  output logic                       frame_done,
  output logic                       overflow
);

  localparam int W  = 4*Data_bit + Class_bit;
  localparam int RW = W + 2;
  localparam int AW = $clog2(FIFO_DEPTH);

  // record layout: {last, null, payload}
  logic [RW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]    head_q, head_d;
  logic             valid_q, valid_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             fd_q, fd_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] det_q, det_d;
  logic [CNT_W-1:0] run_inc;

  logic          full;
  logic          pop;
  logic          push;
  logic [RW-1:0] rec;

  assign full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop  = valid_q & out_if.out_ready;

  always_comb begin
    push   = 1'b0;
    rec    = '0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (pend_q) begin
      if (in_valid | in_frame_last) ovf_d = 1'b1;
      if (!full) begin
        push   = 1'b1;
        rec    = {1'b1, 1'b1, {W{1'b0}}};
        pend_d = 1'b0;
      end
    end else if (in_valid | in_frame_last) begin
      if (!full) begin
        push = 1'b1;
        rec  = {in_frame_last, ~in_valid,
                in_valid ? {in_class, in_h, in_w, in_y, in_x}
                         : {W{1'b0}}};
      end else begin
        if (in_frame_last) pend_d = 1'b1;
        if (in_valid)      ovf_d  = 1'b1;
      end
    end
  end

  always_comb begin
    run_inc = run_q;
    if (push && !rec[W] && run_q != '1) run_inc = run_q + 1'b1;
    run_d = run_inc;
    det_d = det_q;
    fd_d  = 1'b0;
    if (push && rec[W+1]) begin
      det_d = run_inc;
      run_d = '0;
      fd_d  = 1'b1;
    end
  end

  // head follows a write into the slot being exposed
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    valid_d  = (rd_ptr_d != wr_ptr_d);
    if (!valid_d) head_d = '0;
    else if (push && rd_ptr_d == wr_ptr_q) head_d = rec;
    else head_d = mem_q[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rec;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fd_q     <= 1'b0;
      run_q    <= '0;
      det_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      fd_q     <= fd_d;
      run_q    <= run_d;
      det_q    <= det_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = head_q[W-1:0];
  assign out_if.out_null  = head_q[W];
  assign out_if.out_last  = head_q[W+1];
  assign det_count        = det_q;
  assign frame_done       = fd_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_pola_yolo_detection_packer.sv
// Scoreboard bench: queue-based reference model of the packer,
// decoupled monitor comparing each handshaked record.
module tb_pola_yolo_detection_packer;
  localparam int DB    = 16;
  localparam int CB    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int W     = 4*DB + CB;

  typedef logic [W+1:0] rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_frame_last = 1'b0;
  logic signed [DB-1:0] in_x = '0, in_y = '0, in_w = '0, in_h = '0;
  logic [CB-1:0]        in_class = '0;
  logic                 ready = 1'b0;
  logic [CW-1:0]        det_count;
  logic                 frame_done;
  logic                 overflow;

  pola_yolo_detection_packer_if #(.Data_bit(DB), .Class_bit(CB)) bus ();
  assign bus.out_ready = ready;

  pola_yolo_detection_packer #(
    .Data_bit(DB), .Class_bit(CB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .M_AXI_ACLK   (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_w         (in_w),
    .in_h         (in_h),
    .in_class     (in_class),
    .in_frame_last(in_frame_last),
    .out_if       (bus),
    .det_count    (det_count),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  int checks = 0;
  int errors = 0;
  rec_t sb[$];
  bit   pend = 0;
  int   run = 0;
  int   e_det = 0;
  bit   e_fd = 0;
  bit   e_ovf = 0;
  int   fd_cnt = 0;
  int   pops = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: capacity-limited record queue + frame counters
  always @(negedge clk) begin
    rec_t r;
    bit   push;
    bit   full;
    chk("det_count", det_count, e_det);
    chk("frame_done", frame_done, e_fd);
    chk("overflow", overflow, e_ovf);
    if (frame_done) fd_cnt++;
    push = 0;
    r    = '0;
    e_fd = 0;
    if (rst) begin
      sb.delete();
      pend  = 0;
      run   = 0;
      e_det = 0;
      e_ovf = 0;
    end else begin
      full = (sb.size() >= DEPTH);
      if (pend) begin
        if (in_valid || in_frame_last) e_ovf = 1;
        if (!full) begin
          push = 1;
          r    = {1'b1, 1'b1, W'(0)};
          pend = 0;
        end
      end else if (in_valid || in_frame_last) begin
        if (!full) begin
          push = 1;
          r = {in_frame_last, !in_valid,
               in_valid ? {in_class, in_h, in_w, in_y, in_x} : W'(0)};
        end else begin
          if (in_frame_last) pend = 1;
          if (in_valid) e_ovf = 1;
        end
      end
      if (push) begin
        sb.push_back(r);
        if (!r[W] && run < 65535) run = run + 1;
        if (r[W+1]) begin
          e_det = run;
          run   = 0;
          e_fd  = 1;
        end
      end
    end
  end

  rec_t held;
  bit   stalled = 0;
  always @(negedge clk) begin
    rec_t e;
    rec_t got;
    #1;
    got = {bus.out_last, bus.out_null, bus.out_data};
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold", got, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no record", got);
        end else begin
          e = sb.pop_front();
          chk("record", got, e);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = got;
    end
  end

  task automatic drive(bit v, bit l, int x, logic [CB-1:0] c);
    @(posedge clk);
    #1;
    in_valid      = v;
    in_frame_last = l;
    in_x          = DB'(x);
    in_y          = DB'(x * 3 - 7);
    in_w          = DB'(x + 1000);
    in_h          = DB'(-x);
    in_class      = c;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((sb.size() != 0 || pend) && k < budget) begin
      idle(1);
      k++;
    end
    idle(3);
    chk("drain_empty", sb.size(), 0);
    chk("drain_out_valid", bus.out_valid, 0);
  endtask

  int f0;
  int p0;
  int sent;
  int cyc;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_null", bus.out_null, 0);
    chk("rst_out_last", bus.out_last, 0);

    // three candidates, last on the third
    ready = 1;
    f0 = fd_cnt;
    p0 = pops;
    drive(1, 0, 1, 5);
    drive(1, 0, 2, 5);
    drive(1, 1, 3, 5);
    drain(50);
    chk("t1_det", det_count, 3);
    chk("t1_fd", fd_cnt - f0, 1);
    chk("t1_pops", pops - p0, 3);

    // null end-of-frame marker
    f0 = fd_cnt;
    p0 = pops;
    drive(1, 0, 7, 2);
    drive(1, 0, 8, 2);
    drive(0, 1, 0, 0);
    drain(50);
    chk("t2_det", det_count, 2);
    chk("t2_fd", fd_cnt - f0, 1);
    chk("t2_pops", pops - p0, 3);

    // fill past capacity, then end frame while full
    ready = 0;
    p0 = pops;
    for (int i = 0; i < 18; i++) drive(1, 0, 100 + i, 8'(i));
    idle(2);
    chk("t3_overflow", overflow, 1);
    f0 = fd_cnt;
    drive(0, 1, 0, 0);
    idle(5);
    chk("t4_fd_early", fd_cnt - f0, 0);
    ready = 1;
    drain(80);
    chk("t4_pops", pops - p0, 17);
    chk("t4_det", det_count, 16);
    chk("t4_fd", fd_cnt - f0, 1);

    // toggling ready over several pointer wraps
    p0 = pops;
    sent = 0;
    cyc = 0;
    while ((sent < 50 || sb.size() != 0) && cyc < 2000) begin
      @(posedge clk);
      #1;
      ready = ~ready;
      in_valid = 0;
      in_frame_last = 0;
      if (sent < 50 && $urandom_range(0, 3) == 0) begin
        in_valid      = 1;
        in_frame_last = (sent == 49);
        in_x          = DB'($urandom);
        in_y          = DB'($urandom);
        in_w          = DB'($urandom);
        in_h          = DB'($urandom);
        in_class      = CB'($urandom);
        sent++;
      end
      cyc++;
    end
    ready = 1;
    drain(50);
    chk("t5_pops", pops - p0, 50);
    chk("t5_det", det_count, 50);

    // random traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      ready         = ($urandom_range(0, 9) < 6);
      in_valid      = ($urandom_range(0, 9) < 5);
      in_frame_last = ($urandom_range(0, 9) == 0);
      in_x          = DB'($urandom);
      in_y          = DB'($urandom);
      in_w          = DB'($urandom);
      in_h          = DB'($urandom);
      in_class      = CB'($urandom);
    end
    drive(0, 1, 0, 0);
    ready = 1;
    drain(100);

    // reset with records buffered
    ready = 0;
    for (int i = 0; i < 7; i++) drive(1, 0, 200 + i, 3);
    idle(1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_det", det_count, 0);
    chk("t6_overflow", overflow, 0);
    ready = 1;
    p0 = pops;
    drive(1, 1, 42, 9);
    drain(50);
    chk("t6_det_after", det_count, 1);
    chk("t6_pops", pops - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
